consensus_vector_checker: RTL
=============================

// Module: consensus_vector_checker
// PURPOSE
//  Sequential stimulus-and-compare stage wrapped around the 3-input consensus function F = XY | X'Z | YZ (== XY | X'Z).
//  Drives registered X,Y,Z into both the unsimplified and simplified implementations, consumes their two outputs,
//  and checks them against each other and against an internal golden value EXP = X ? Y : Z.
//  Sits at lab top level; one START runs an exhaustive 8-vector sweep and reports PASS/mismatch count.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles between driving a vector and sampling OUT_A/OUT_B (legal 1..15)
//  CNT_W          4  width of MISMATCH_CNT (saturating)
// PORTS
//  CLK           in   1      rising-edge clock
//  RST           in   1      asynchronous, active-high reset
//  START         in   1      begin sweep; sampled only in IDLE
//  ABORT         in   1      cancel sweep in progress
//  OUT_A         in   1      output of unsimplified implementation
//  OUT_B         in   1      output of simplified implementation
//  X, Y, Z       out  1 ea   registered stimulus to both implementations
//  BUSY          out  1      high in DRIVE/SETTLE/SAMPLE
//  DONE          out  1      one-cycle pulse at end of completed sweep
//  PASS          out  1      valid when DONE; held until next START
//  MISMATCH_CNT  out  CNT_W  vectors failing either comparison
// BEHAVIOUR
//  Reset: one clock; RST asynchronous active-high; all outputs 0, state IDLE, vec=0.
//  States: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | FINISH) -> IDLE.
//  IDLE: START=1 -> clear MISMATCH_CNT, PASS<=0, vec<=0, go DRIVE. START in any other state ignored.
//  DRIVE (1 cycle): {X,Y,Z} <= vec[2:0]; settle counter <= SETTLE_CYCLES-1.
//  SETTLE: hold X,Y,Z; count down; exit at 0 (SETTLE_CYCLES=1 -> exactly 1 cycle here).
//  SAMPLE (1 cycle): fail = (OUT_A!=OUT_B) | (OUT_A!=EXP) | (OUT_B!=EXP), EXP from registered X,Y,Z.
//   fail -> MISMATCH_CNT+1, saturating at 2^CNT_W-1 (no wrap). vec==7 -> FINISH else vec+1, DRIVE.
//  Latency per vector = SETTLE_CYCLES+2 cycles; START-accept to DONE = 8*(SETTLE_CYCLES+2)+1 cycles.
//  FINISH (1 cycle): DONE=1, PASS = (MISMATCH_CNT==0) incl. same-cycle update; next IDLE. X,Y,Z hold last vector.
//  ABORT=1 in DRIVE/SETTLE/SAMPLE: next state IDLE, no DONE, PASS=0, count frozen; ABORT wins over same-cycle sample.
//  ABORT in IDLE/FINISH: no effect. START and ABORT together in IDLE: START accepted.
//  RST mid-sweep: immediate return to reset values; no DONE.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined: adds outputs FIRST_FAIL_VLD (1) and FIRST_FAIL_VEC (3); on first failing SAMPLE
//   of a sweep latch vec, set VLD; cleared on START and RST; unaffected by later failures.
//  Not defined: ports absent; no capture logic.
// STRUCTURE
//  Shared package: state encoding (IDLE,DRIVE,SETTLE,SAMPLE,FINISH), NUM_VEC=8, VEC_W=3.
//  One sub-module: consensus_golden (comb EXP = X ? Y : Z); FSM, counters, saturation inline.
// TESTING
//  1 Both DUTs correct, SETTLE=1: START pulse -> DONE at cycle 25 after accept, PASS=1, MISMATCH_CNT=0.
//  2 OUT_B stuck-at-0: sweep -> MISMATCH_CNT=4 (vecs 1,3,6,7), PASS=0; with _EN, FIRST_FAIL_VEC=1.
//  3 OUT_A inverted, CNT_W=2: sweep -> MISMATCH_CNT saturates at 3, no wrap, PASS=0.
//  4 ABORT during vec 4 SAMPLE: -> IDLE next cycle, DONE never pulses, PASS=0, count unchanged.
//  5 RST asserted mid-SETTLE, async to CLK: all outputs 0 immediately; later START runs full clean sweep.
//  6 SETTLE_CYCLES=3, START re-pulsed while BUSY: ignored; DONE at 8*5+1=41 cycles after first accept.

Source files
------------

// File: rtl/consensus_vector_checker_pkg.sv
// Shared types and constants for the consensus vector checker.
package consensus_vector_checker_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/consensus_golden.sv
// Golden reference for the consensus function: XY | X'Z | YZ reduces to a mux on X.
module consensus_golden (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic exp_o
);

  assign exp_o = x_i ? y_i : z_i;

endmodule

// File: rtl/consensus_vector_checker.sv
// Exhaustive 8-vector sweep comparing two consensus implementations against a golden value.
// Optional FIRST_FAIL_CAPTURE_EN adds first_fail_vld_o / first_fail_vec_o.
//
// state  | meaning
// IDLE   | waiting for start_i
// DRIVE  | register the current vector onto x/y/z
// SETTLE | wait for the implementations to settle
// SAMPLE | compare outputs, count failures, advance vector
// FINISH | raise done/pass for the completed sweep
module consensus_vector_checker
  import consensus_vector_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             out_a_i,
  input  logic             out_b_i,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic             first_fail_vld_o,
  output logic [VEC_W-1:0] first_fail_vec_o,
`endif
  output logic             x_o,
  output logic             y_o,
  output logic             z_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);

  state_e           state_q;
  logic [VEC_W-1:0] vec_q;
  logic [3:0]       settle_q;
  logic             x_q, y_q, z_q;
  logic             done_q, pass_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_w, fail_w;

  consensus_golden u_golden (
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
    .exp_o (exp_w)
  );

  assign fail_w = (out_a_i != out_b_i) | (out_a_i != exp_w) | (out_b_i != exp_w);
  // Saturate rather than wrap so a narrow counter still reports "many failures".
  assign cnt_d  = (fail_w && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic             ff_vld_q;
  logic [VEC_W-1:0] ff_vec_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (state_q == ST_SAMPLE && !abort_i && fail_w && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_vec_q <= vec_q;
    end
  end

  assign first_fail_vld_o = ff_vld_q;
  assign first_fail_vec_o = ff_vec_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (abort_i) begin
            pass_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            {x_q, y_q, z_q} <= vec_q;
            settle_q        <= 4'(SETTLE_CYCLES - 1);
            state_q         <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort_i) begin
            pass_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (settle_q == 4'd0) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (abort_i) begin
            pass_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (vec_q == VEC_W'(NUM_VEC - 1)) begin
              state_q <= ST_FINISH;
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= ST_DRIVE;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          pass_q  <= (cnt_q == '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign z_o            = z_q;
  assign busy_o         = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign mismatch_cnt_o = cnt_q;

endmodule
